// File: rtl/rx_initiated_sweep_test_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rx_initiated_sweep_test_tx_if: sideband wrapper/encoder handshake bundle  |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface rx_initiated_sweep_test_tx_if #(
  parameter int unsigned SB_MSG_WIDTH = 4
);
  logic                    i_falling_edge_busy;
  logic                    i_rx_valid;
  logic                    i_rx_msg_valid;
  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg;
  logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx;
  logic                    o_sb_data_pattern;
  logic                    o_sb_burst_count;
  logic                    o_sb_comparison_mode;
  logic [1:0]              o_clock_phase;
  logic                    o_tx_data_valid;
  logic                    o_valid_tx;

  modport master (
    input  i_falling_edge_busy, i_rx_valid, i_rx_msg_valid, i_decoded_SB_msg,
    output o_encoded_SB_msg_tx, o_sb_data_pattern, o_sb_burst_count,
           o_sb_comparison_mode, o_clock_phase, o_tx_data_valid, o_valid_tx
  );

  modport slave (
    output i_falling_edge_busy, i_rx_valid, i_rx_msg_valid, i_decoded_SB_msg,
    input  o_encoded_SB_msg_tx, o_sb_data_pattern, o_sb_burst_count,
           o_sb_comparison_mode, o_clock_phase, o_tx_data_valid, o_valid_tx
  );
endinterface
`default_nettype wire

// File: rtl/rx_initiated_sweep_test_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rx_initiated_sweep_test_tx: TX sequencer for a multi-point RX-initiated   |
// | data-to-clock sweep with per-handshake sideband timeout.  rev 1.0         |
// +--------------------------------------------------------------------------+
module rx_initiated_sweep_test_tx #(
  parameter int unsigned          SB_MSG_WIDTH = 4,
  parameter int unsigned          PT_CNT_W     = 4,
  parameter int unsigned          TIMEOUT_W    = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC  = 16'd8000
) (
  input  wire logic                i_clk,
  input  wire logic                i_rst_n,
  input  wire logic                i_sweep_en,
  input  wire logic                i_datavref_or_valvref,
  input  wire logic [PT_CNT_W-1:0] i_num_points,
  input  wire logic                i_pattern_finished,
  rx_initiated_sweep_test_tx_if.master sb,
  output logic                     o_val_pattern_en,
  output logic [1:0]               o_mainband_pattern_generator_cw,
  output logic [PT_CNT_W-1:0]      o_point_index,
  output logic                     o_sweep_done,
  output logic                     o_timeout_err
);

  localparam logic [SB_MSG_WIDTH-1:0] C_START_REQ      = SB_MSG_WIDTH'(1);
  localparam logic [SB_MSG_WIDTH-1:0] C_START_RESP     = SB_MSG_WIDTH'(2);
  localparam logic [SB_MSG_WIDTH-1:0] C_LFSR_CLR_REQ   = SB_MSG_WIDTH'(3);
  localparam logic [SB_MSG_WIDTH-1:0] C_LFSR_CLR_RESP  = SB_MSG_WIDTH'(4);
  localparam logic [SB_MSG_WIDTH-1:0] C_COUNT_DONE_REQ = SB_MSG_WIDTH'(5);
  localparam logic [SB_MSG_WIDTH-1:0] C_COUNT_DONE_RSP = SB_MSG_WIDTH'(6);
  localparam logic [SB_MSG_WIDTH-1:0] C_END_REQ        = SB_MSG_WIDTH'(7);
  localparam logic [SB_MSG_WIDTH-1:0] C_END_RESP       = SB_MSG_WIDTH'(8);
  localparam logic [1:0]              C_CW_IDLE        = 2'b00;
  localparam logic [1:0]              C_CW_CLR         = 2'b01;
  localparam logic [1:0]              C_CW_LFSR        = 2'b10;
  localparam logic [TIMEOUT_W-1:0]    C_TMO_LAST       = TIMEOUT_CYC - TIMEOUT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_PARTNER, S_START_REQ, S_LFSR_CLEAR, S_SEND_PATTERN,
    S_COUNT_DONE, S_END_REQ, S_DONE, S_ERROR
  } state_e;

  state_e                  state_q, state_d;
  logic                    entry_q;
  logic [TIMEOUT_W-1:0]    tmo_q, tmo_d;
  logic [PT_CNT_W-1:0]     idx_q, idx_d, pts_q, pts_d, pidx_q, pidx_d;
  logic                    mode_q, mode_d;
  logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
  logic                    vtx_q, vtx_d, tdv_q, tdv_d, burst_q, burst_d;
  logic                    vpe_q, vpe_d, done_q, done_d, err_q, err_d;
  logic [1:0]              cw_q, cw_d;

  logic w_start_resp, w_clr_resp, w_cd_resp, w_end_resp;
  logic w_expired, w_last, w_waiting;

  // Only a valid-qualified decoded code counts as a response.
  assign w_start_resp = sb.i_rx_msg_valid && (sb.i_decoded_SB_msg == C_START_RESP);
  assign w_clr_resp   = sb.i_rx_msg_valid && (sb.i_decoded_SB_msg == C_LFSR_CLR_RESP);
  assign w_cd_resp    = sb.i_rx_msg_valid && (sb.i_decoded_SB_msg == C_COUNT_DONE_RSP);
  assign w_end_resp   = sb.i_rx_msg_valid && (sb.i_decoded_SB_msg == C_END_RESP);
  assign w_expired    = (tmo_q == C_TMO_LAST);
  assign w_last       = (idx_q == pts_q - PT_CNT_W'(1));
  assign w_waiting    = (state_q == S_START_REQ) || (state_q == S_LFSR_CLEAR) ||
                        (state_q == S_COUNT_DONE) || (state_q == S_END_REQ);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pts_d   = pts_q;
    mode_d  = mode_q;
    tmo_d   = '0;
    case (state_q)
      S_IDLE: begin
        pts_d  = (i_num_points == '0) ? PT_CNT_W'(1) : i_num_points;
        mode_d = i_datavref_or_valvref;
        idx_d  = '0;
        if (i_sweep_en)
          state_d = (sb.i_decoded_SB_msg == C_START_REQ) ? S_WAIT_PARTNER : S_START_REQ;
      end
      S_WAIT_PARTNER: if (sb.i_falling_edge_busy && sb.i_rx_valid) state_d = S_START_REQ;
      S_START_REQ: begin
        if (w_start_resp)   state_d = S_LFSR_CLEAR;
        else if (w_expired) state_d = S_ERROR;
      end
      S_LFSR_CLEAR: begin
        if (w_clr_resp)     state_d = S_SEND_PATTERN;
        else if (w_expired) state_d = S_ERROR;
      end
      S_SEND_PATTERN: if (i_pattern_finished) state_d = S_COUNT_DONE;
      S_COUNT_DONE: begin
        if (w_cd_resp) begin
          if (w_last) begin
            state_d = S_END_REQ;
          end else begin
            idx_d   = idx_q + PT_CNT_W'(1);
            state_d = S_LFSR_CLEAR;
          end
        end else if (w_expired) begin
          state_d = S_ERROR;
        end
      end
      S_END_REQ: begin
        if (w_end_resp)     state_d = S_DONE;
        else if (w_expired) state_d = S_ERROR;
      end
      default: ;
    endcase
    if (!i_sweep_en) state_d = S_IDLE;
    if ((state_d == state_q) && w_waiting) tmo_d = tmo_q + TIMEOUT_W'(1);
  end

  // Outputs follow the state one cycle late; entry_q marks the first cycle in a state.
  always_comb begin
    msg_d   = msg_q;
    vtx_d   = vtx_q;
    tdv_d   = tdv_q;
    burst_d = burst_q;
    vpe_d   = vpe_q;
    cw_d    = cw_q;
    pidx_d  = idx_q;
    done_d  = done_q;
    err_d   = err_q;
    if (state_q == S_IDLE) begin
      msg_d   = '0;
      vtx_d   = 1'b0;
      tdv_d   = 1'b0;
      burst_d = 1'b0;
      vpe_d   = 1'b0;
      cw_d    = C_CW_IDLE;
      pidx_d  = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      if (sb.i_falling_edge_busy && !sb.i_rx_valid) vtx_d = 1'b0;
      if (!vtx_q) tdv_d = 1'b0;
      if (entry_q) begin
        case (state_q)
          S_START_REQ: begin
            msg_d   = C_START_REQ;
            vtx_d   = 1'b1;
            tdv_d   = 1'b1;
            burst_d = !mode_q;
          end
          S_LFSR_CLEAR: begin
            msg_d = C_LFSR_CLR_REQ;
            vtx_d = 1'b1;
            if (!mode_q) cw_d = C_CW_CLR;
          end
          S_SEND_PATTERN: begin
            if (mode_q) vpe_d = 1'b1;
            else        cw_d  = C_CW_LFSR;
          end
          S_COUNT_DONE: begin
            msg_d = C_COUNT_DONE_REQ;
            vtx_d = 1'b1;
            cw_d  = C_CW_IDLE;
            vpe_d = 1'b0;
          end
          S_END_REQ: begin
            msg_d = C_END_REQ;
            vtx_d = 1'b1;
          end
          S_DONE: done_d = 1'b1;
          S_ERROR: begin
            err_d = 1'b1;
            cw_d  = C_CW_IDLE;
            vpe_d = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      entry_q <= 1'b0;
      tmo_q   <= '0;
      idx_q   <= '0;
      pts_q   <= '0;
      mode_q  <= 1'b0;
      msg_q   <= '0;
      vtx_q   <= 1'b0;
      tdv_q   <= 1'b0;
      burst_q <= 1'b0;
      vpe_q   <= 1'b0;
      cw_q    <= C_CW_IDLE;
      pidx_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= (state_d != state_q);
      tmo_q   <= tmo_d;
      idx_q   <= idx_d;
      pts_q   <= pts_d;
      mode_q  <= mode_d;
      msg_q   <= msg_d;
      vtx_q   <= vtx_d;
      tdv_q   <= tdv_d;
      burst_q <= burst_d;
      vpe_q   <= vpe_d;
      cw_q    <= cw_d;
      pidx_q  <= pidx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sb.o_encoded_SB_msg_tx           = msg_q;
  assign sb.o_sb_data_pattern             = 1'b0;
  assign sb.o_sb_burst_count              = burst_q;
  assign sb.o_sb_comparison_mode          = 1'b0;
  assign sb.o_clock_phase                 = 2'b00;
  assign sb.o_tx_data_valid               = tdv_q;
  assign sb.o_valid_tx                    = vtx_q;
  assign o_val_pattern_en                 = vpe_q;
  assign o_mainband_pattern_generator_cw  = cw_q;
  assign o_point_index                    = pidx_q;
  assign o_sweep_done                     = done_q;
  assign o_timeout_err                    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_initiated_sweep_test_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rx_initiated_sweep_test_tx: directed bench with partner/pattern model  |
// | and a request scoreboard.  rev 1.0                                        |
// +--------------------------------------------------------------------------+
module tb_rx_initiated_sweep_test_tx;
  localparam int SBW = 4;
  localparam int PW  = 4;

  typedef struct packed {
    logic [SBW-1:0] msg;
    logic [PW-1:0]  idx;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           en = 1'b0, mode = 1'b0, pat_fin = 1'b0;
  logic           busy_auto = 1'b0, busy_man = 1'b0, rxv = 1'b0;
  logic           auto_vld = 1'b0, man_sel = 1'b0;
  logic [PW-1:0]  npts = '0;
  logic [SBW-1:0] auto_msg = '0, man_msg = '0, rsp_code = '0, block_code = '0;
  logic           vpe, done, err;
  logic [1:0]     cw;
  logic [PW-1:0]  pidx;

  rx_initiated_sweep_test_tx_if #(.SB_MSG_WIDTH(SBW)) sb_if ();
  assign sb_if.i_falling_edge_busy = busy_auto | busy_man;
  assign sb_if.i_rx_valid          = rxv;
  assign sb_if.i_rx_msg_valid      = man_sel | auto_vld;
  assign sb_if.i_decoded_SB_msg    = man_sel ? man_msg : auto_msg;

  rx_initiated_sweep_test_tx #(
    .SB_MSG_WIDTH(SBW), .PT_CNT_W(PW), .TIMEOUT_W(16), .TIMEOUT_CYC(16'd20)
  ) dut (
    .i_clk                           (clk),
    .i_rst_n                         (rst_n),
    .i_sweep_en                      (en),
    .i_datavref_or_valvref           (mode),
    .i_num_points                    (npts),
    .i_pattern_finished              (pat_fin),
    .sb                              (sb_if.master),
    .o_val_pattern_en                (vpe),
    .o_mainband_pattern_generator_cw (cw),
    .o_point_index                   (pidx),
    .o_sweep_done                    (done),
    .o_timeout_err                   (err)
  );

  req_t       sb_q[$];
  logic [1:0] cw_log[$];
  int ncmp = 0, nfail = 0, cyc = 0, t_req = 0, vpe_rises = 0;
  int rsp_dly = 5, rsp_cnt = -1, busy_cnt = -1, pat_cnt = -1;
  logic prev_vtx = 1'b0, prev_pat = 1'b0, prev_vpe = 1'b0;
  logic [1:0] prev_cw = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_msg"},   32'(sb_if.o_encoded_SB_msg_tx), 0);
    check({p, "_vtx"},   32'(sb_if.o_valid_tx), 0);
    check({p, "_tdv"},   32'(sb_if.o_tx_data_valid), 0);
    check({p, "_burst"}, 32'(sb_if.o_sb_burst_count), 0);
    check({p, "_vpe"},   32'(vpe), 0);
    check({p, "_cw"},    32'(cw), 0);
    check({p, "_pidx"},  32'(pidx), 0);
    check({p, "_done"},  32'(done), 0);
    check({p, "_err"},   32'(err), 0);
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return done;
      1:       return err;
      default: return (pidx == PW'(1)) && (cw == 2'b10);
    endcase
  endfunction

  task automatic wait_cond(input int sel, input int bound);
    for (int i = 0; i < bound && !cond(sel); i++) @(negedge clk);
  endtask

  task automatic push(input int m, input int i);
    req_t r;
    r.msg = SBW'(m);
    r.idx = PW'(i);
    sb_q.push_back(r);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Partner, SB wrapper and pattern generator models plus request scoreboard.
  always @(negedge clk) begin
    req_t r;
    auto_vld  = 1'b0;
    busy_auto = 1'b0;
    pat_fin   = 1'b0;
    if (rsp_cnt == 0) begin auto_msg = rsp_code; auto_vld = 1'b1; end
    if (rsp_cnt >= 0) rsp_cnt--;
    if (busy_cnt == 0) busy_auto = 1'b1;
    if (busy_cnt >= 0) busy_cnt--;
    if (pat_cnt == 0) pat_fin = 1'b1;
    if (pat_cnt >= 0) pat_cnt--;
    if (!prev_vtx && sb_if.o_valid_tx) begin
      t_req    = cyc;
      busy_cnt = 2;
      ncmp++;
      assert (sb_q.size() != 0) else begin
        nfail++;
        $error("FAIL unexpected_req: observed msg %0d expected none", sb_if.o_encoded_SB_msg_tx);
      end
      if (sb_q.size() != 0) begin
        r = sb_q.pop_front();
        check("sb_req_msg", 32'(sb_if.o_encoded_SB_msg_tx), 32'(r.msg));
        check("sb_req_idx", 32'(pidx), 32'(r.idx));
      end
      if (sb_if.o_encoded_SB_msg_tx != block_code) begin
        rsp_code = sb_if.o_encoded_SB_msg_tx + SBW'(1);
        rsp_cnt  = rsp_dly;
      end
    end
    if (!prev_pat && ((cw == 2'b10) || vpe)) pat_cnt = 3;
    if (cw != prev_cw) cw_log.push_back(cw);
    if (!prev_vpe && vpe) vpe_rises++;
    prev_vtx = sb_if.o_valid_tx;
    prev_pat = (cw == 2'b10) || vpe;
    prev_vpe = vpe;
    prev_cw  = cw;
  end

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Data sweep, three points.
    rsp_dly = 5; mode = 1'b0; npts = PW'(3);
    cw_log.delete();
    push(1, 0); push(3, 0); push(5, 0); push(3, 1); push(5, 1); push(3, 2); push(5, 2); push(7, 2);
    en = 1'b1;
    wait_cond(0, 2000);
    check("A_done", 32'(done), 1);
    check("A_burst", 32'(sb_if.o_sb_burst_count), 1);
    check("A_pidx", 32'(pidx), 2);
    check("A_err", 32'(err), 0);
    check("A_sb_empty", 32'(sb_q.size()), 0);
    check("A_cw_len", 32'(cw_log.size()), 9);
    for (int i = 0; i < 9 && i < cw_log.size(); i++)
      check("A_cw_seq", 32'(cw_log[i]), (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 2 : 0));
    repeat (3) @(negedge clk);
    check("A_done_hold", 32'(done), 1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("A_idle_done", 32'(done), 0);

    // Valid sweep, zero points requested, started by partner START_REQ.
    mode = 1'b1; npts = '0;
    cw_log.delete();
    vpe_rises = 0;
    push(1, 0); push(3, 0); push(5, 0); push(7, 0);
    man_sel = 1'b1; man_msg = SBW'(1); en = 1'b1;
    @(negedge clk);
    man_sel = 1'b0;
    repeat (6) @(negedge clk);
    check("B_wait_vtx", 32'(sb_if.o_valid_tx), 0);
    check("B_wait_msg", 32'(sb_if.o_encoded_SB_msg_tx), 0);
    busy_man = 1'b1; rxv = 1'b1;
    @(negedge clk);
    busy_man = 1'b0; rxv = 1'b0;
    repeat (2) @(negedge clk);
    check("B_start_vtx", 32'(sb_if.o_valid_tx), 1);
    check("B_start_msg", 32'(sb_if.o_encoded_SB_msg_tx), 1);
    check("B_start_tdv", 32'(sb_if.o_tx_data_valid), 1);
    wait_cond(0, 2000);
    check("B_done", 32'(done), 1);
    check("B_burst", 32'(sb_if.o_sb_burst_count), 0);
    check("B_vpe_pulses", 32'(vpe_rises), 1);
    check("B_vpe_low", 32'(vpe), 0);
    check("B_cw_changes", 32'(cw_log.size()), 0);
    check("B_pidx", 32'(pidx), 0);
    check("B_sb_empty", 32'(sb_q.size()), 0);
    en = 1'b0;
    repeat (3) @(negedge clk);

    // Timeout: partner never answers LFSR_CLR_REQ.
    mode = 1'b0; npts = PW'(1); block_code = SBW'(3);
    push(1, 0); push(3, 0);
    en = 1'b1;
    wait_cond(1, 400);
    check("C_err", 32'(err), 1);
    check("C_err_latency", 32'(cyc - t_req), 20);
    check("C_cw", 32'(cw), 0);
    check("C_vpe", 32'(vpe), 0);
    check("C_done", 32'(done), 0);
    repeat (3) @(negedge clk);
    check("C_err_hold", 32'(err), 1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("C_idle");
    block_code = '0;
    check("C_sb_empty", 32'(sb_q.size()), 0);

    // Every response lands on the timeout expiry cycle.
    rsp_dly = 17; mode = 1'b0; npts = PW'(2);
    push(1, 0); push(3, 0); push(5, 0); push(3, 1); push(5, 1); push(7, 1);
    en = 1'b1;
    wait_cond(0, 2000);
    check("D_done", 32'(done), 1);
    check("D_err", 32'(err), 0);
    check("D_pidx", 32'(pidx), 1);
    check("D_sb_empty", 32'(sb_q.size()), 0);
    en = 1'b0;
    repeat (3) @(negedge clk);

    // Abort mid-pattern at point 1.
    rsp_dly = 5; mode = 1'b0; npts = PW'(3);
    push(1, 0); push(3, 0); push(5, 0); push(3, 1);
    en = 1'b1;
    wait_cond(2, 1000);
    check("E_reach_p1", 32'(cond(2)), 1);
    en = 1'b0;
    @(negedge clk);
    check("E_cw_lag", 32'(cw), 2);
    @(negedge clk);
    check("E_cw", 32'(cw), 0);
    check("E_vpe", 32'(vpe), 0);
    check("E_pidx", 32'(pidx), 0);
    check("E_vtx", 32'(sb_if.o_valid_tx), 0);
    repeat (30) @(negedge clk);
    check("E_sb_empty", 32'(sb_q.size()), 0);
    check("E_stay_idle_msg", 32'(sb_if.o_encoded_SB_msg_tx), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rx_initiated_sweep_test_tx.md
Name: rx_initiated_sweep_test_tx

Overview:
- TX-side sequencer for an RX-initiated data-to-clock test that runs multiple test points per session. The original single-point sequence generalises to a loop: LFSR clear, then pattern burst, then count-done, repeated for a programmable number of points.
- Adds a per-handshake sideband timeout with an error exit, and a parametrised SB message width.
- Sits between the LTSM, the sideband wrapper/encoder and the mainband pattern generator.

Parameters:
- SB_MSG_WIDTH, 4: width of encoded/decoded SB message codes.
- PT_CNT_W, 4: width of the point count and point index.
- TIMEOUT_W, 16: width of the timeout counter.
- TIMEOUT_CYC, 16'd8000: cycles allowed in any SB-response wait state before error.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  async active-low reset.
- i_sweep_en  in  1  LTSM enable; low aborts to IDLE from any state.
- i_datavref_or_valvref  in  1  0: data (LFSR), 1: valid pattern.
- i_num_points  in  PT_CNT_W  number of points; sampled on leaving IDLE; 0 treated as 1.
- i_falling_edge_busy  in  1  SB wrapper finished sending current message.
- i_rx_valid  in  1  local RX path currently driving the wrapper.
- i_pattern_finished  in  1  pattern generator burst complete (1-cycle pulse).
- i_rx_msg_valid  in  1  decoded SB message valid.
- i_decoded_SB_msg  in  SB_MSG_WIDTH  decoded partner message.
- o_encoded_SB_msg_tx  out  SB_MSG_WIDTH  message code to SB encoder.
- o_sb_data_pattern  out  1  always 0 (LFSR).
- o_sb_burst_count  out  1  1 if data (4k), 0 if valid (1k).
- o_sb_comparison_mode  out  1  always 0 (per-lane).
- o_clock_phase  out  2  always 0 (eye centre).
- o_tx_data_valid  out  1  data-field valid, set with START_REQ.
- o_valid_tx  out  1  message valid to wrapper.
- o_val_pattern_en  out  1  valid-pattern enable.
- o_mainband_pattern_generator_cw  out  2  00 IDLE, 01 CLEAR_LFSR, 10 LFSR.
- o_point_index  out  PT_CNT_W  current point, 0-based.
- o_sweep_done  out  1  level; all points finished and END handshake complete.
- o_timeout_err  out  1  level; a wait state expired.

Behaviour:
- Message codes: START_REQ=1, START_RESP=2, LFSR_CLR_REQ=3, LFSR_CLR_RESP=4, COUNT_DONE_REQ=5, COUNT_DONE_RESP=6, END_REQ=7, END_RESP=8.
- Reset: every output 0, state IDLE, point counter 0, timeout counter 0.
- All outputs are registered. Each one updates the cycle after the transition that causes it.
- States and transitions:
  - IDLE: if en and the decoded msg is START_REQ, go to WAIT_PARTNER; else if en, go to START_REQ. Latch num_points; the index is cleared.
  - WAIT_PARTNER: when falling_edge_busy and rx_valid are both high, go to START_REQ.
  - START_REQ: on START_RESP with msg_valid, go to LFSR_CLEAR.
  - LFSR_CLEAR: on LFSR_CLR_RESP with msg_valid, go to SEND_PATTERN.
  - SEND_PATTERN: on pattern_finished, go to COUNT_DONE.
  - COUNT_DONE: on COUNT_DONE_RESP with msg_valid:
    - if index < latched_points-1: index+1, go to LFSR_CLEAR (re-sends LFSR_CLR_REQ, cw=01);
    - else go to END_REQ.
  - END_REQ: on END_RESP with msg_valid, go to DONE.
  - DONE: hold o_sweep_done=1.
  - ERROR: hold o_timeout_err=1.
  - DONE and ERROR exit to IDLE only when en is low.
- Enable low in any state returns to IDLE next cycle. In IDLE, all data outputs are cleared.
- Message outputs on entering each state:
  - START_REQ: msg=1, field outputs as listed, o_tx_data_valid=1.
  - LFSR_CLEAR: msg=3, cw=01.
  - SEND_PATTERN: data gives cw=10; valid gives val_pattern_en=1.
  - COUNT_DONE: msg=5, cw=00, val_pattern_en=0.
  - END_REQ: msg=7.
- o_valid_tx: set on entry to START_REQ, LFSR_CLEAR, COUNT_DONE and END_REQ. Cleared on falling_edge_busy while rx_valid is low. Set has priority over clear.
- o_tx_data_valid: cleared when o_valid_tx is low, unless set the same cycle.
- Timeout: the counter clears on every state change.
  - It increments each cycle in START_REQ, LFSR_CLEAR, COUNT_DONE and END_REQ.
  - When it reaches TIMEOUT_CYC-1 without the expected response, go to ERROR. Pattern generator cw goes to 00 and val_pattern_en to 0.
  - SEND_PATTERN and WAIT_PARTNER do not time out.
  - A response arriving on the expiry cycle wins; no error is raised.
- Responses other than the expected code, or arriving with msg_valid low, are ignored.
- Point counter saturates at its final value. o_point_index holds its final value through END_REQ and DONE.

Test Plan:
- Data sweep, i_num_points=3, partner answers each request 5 cycles later:
  - 3 LFSR_CLR_REQ/COUNT_DONE_REQ pairs, o_point_index 0,1,2;
  - cw sequence 01,10,00 three times;
  - END_REQ, then o_sweep_done=1, o_sb_burst_count=1.
- Valid sweep, i_num_points=0: runs exactly one point, o_val_pattern_en pulses high during SEND_PATTERN, o_sb_burst_count=0, cw stays 00.
- Partner START_REQ seen in IDLE: FSM waits in WAIT_PARTNER until falling_edge_busy&&rx_valid, then sends msg=1 with o_valid_tx=1.
- TIMEOUT_CYC=20, no LFSR_CLR_RESP: o_timeout_err=1 after 20 cycles in LFSR_CLEAR; drop en, giving IDLE with all outputs 0.
- COUNT_DONE_RESP arriving on the expiry cycle: no error, proceeds to the next point.
- i_sweep_en dropped mid-SEND_PATTERN at point 1: next cycle IDLE; the following cycle cw=00, val_pattern_en=0, o_point_index=0.
